// File: rtl/two_wire_pkg.sv
// Shared definitions for the two-wire serial link (transmitter, receiver, bench).
package two_wire_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic SCLK_IDLE = 1'b1;
    localparam logic SDAT_IDLE = 1'b1;

    // Busy duration of one frame: start half-bit, payload (+parity) bits, stop bit.
    function automatic int frame_cycles(input int data_w, input int clk_div, input int p);
        return clk_div / 2 + (data_w + p + 1) * clk_div;
    endfunction

endpackage

// File: rtl/two_wire_tx_bit_timer.sv
// Half-bit timer for two_wire_tx: free-running down-counter that pulses
// half_tick for one cycle every HALF cycles, restarted by load.
module tx_bit_timer #(
    parameter int HALF = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic half_tick
);

    localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        half_tick = (cnt_q == '0) && !load;
        cnt_d     = cnt_q - TW'(1);
        if (load || half_tick) begin
            cnt_d = TW'(HALF - 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= TW'(HALF - 1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/two_wire_tx.sv
// Two-wire synchronous serial transmitter (start/stop framed, MSB first).
// Optional even-parity bit when TWO_WIRE_TX_PARITY_EN is defined.
module two_wire_tx
    import two_wire_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              sclk_o,
    output logic              sdat_o
);

    localparam int CW   = $clog2(DATA_W + 1);
    localparam int HALF = CLK_DIV / 2;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic              sdat_q, sdat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timer_load;
    logic              half_tick;
`ifdef TWO_WIRE_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    tx_bit_timer #(
        .HALF (HALF)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .half_tick (half_tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        sdat_d     = sdat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
`ifdef TWO_WIRE_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START;
                    shreg_d    = din;
                    bit_cnt_d  = CW'(DATA_W);
                    sclk_d     = SCLK_IDLE;
                    sdat_d     = 1'b0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
`ifdef TWO_WIRE_TX_PARITY_EN
                    parity_d   = ^din;
`endif
                end
            end
            START: begin
                if (half_tick) begin
                    state_d   = DATA;
                    sclk_d    = 1'b0;
                    sdat_d    = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (half_tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == '0) begin
                        sclk_d  = 1'b0;
`ifdef TWO_WIRE_TX_PARITY_EN
                        state_d = PARITY;
                        sdat_d  = parity_q;
`else
                        state_d = STOP;
                        sdat_d  = 1'b0;
`endif
                    end else begin
                        sclk_d    = 1'b0;
                        sdat_d    = shreg_q[DATA_W-1];
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q - CW'(1);
                    end
                end
            end
`ifdef TWO_WIRE_TX_PARITY_EN
            PARITY: begin
                if (half_tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        state_d = STOP;
                        sclk_d  = 1'b0;
                        sdat_d  = 1'b0;
                    end
                end
            end
`endif
            STOP: begin
                // Data rising while the clock is high marks the stop condition.
                if (half_tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sdat_d  = SDAT_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = SCLK_IDLE;
                sdat_d  = SDAT_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sclk_q    <= SCLK_IDLE;
            sdat_q    <= SDAT_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef TWO_WIRE_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            sdat_q    <= sdat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef TWO_WIRE_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // NOTE: pure datapath register, left without reset; it is always loaded on accept before use.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sclk_o = sclk_q;
    assign sdat_o = sdat_q;

endmodule

// File: tb/tb_two_wire_tx.sv
// Scoreboard bench for two_wire_tx: a line monitor decodes frames from
// sclk_o/sdat_o and compares them against words queued at stimulus time.
module tb_two_wire_tx;
    import two_wire_pkg::*;

    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 50;
    localparam int HALF    = CLK_DIV / 2;
`ifdef TWO_WIRE_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = frame_cycles(DATA_W, CLK_DIV, P);

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] din   = '0;
    logic              busy, done, sclk_o, sdat_o;

    two_wire_tx #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .busy   (busy),
        .done   (done),
        .sclk_o (sclk_o),
        .sdat_o (sdat_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    logic [DATA_W-1:0] exp_q[$];

    // Line monitor, sampling at the falling edge.
    int                cyc        = 0;
    logic              prev_sclk  = 1'b1;
    logic              prev_sdat  = 1'b1;
    logic              prev_busy  = 1'b0;
    bit                in_frame   = 1'b0;
    bit                fell       = 1'b0;
    int                nbits      = 0;
    int                start_cyc  = 0;
    int                busy_start = 0;
    int                idle_run   = 0;
    int                last_gap   = -1;
    int                frames     = 0;
    logic [63:0]       bits       = '0;
    logic [DATA_W-1:0] exp_w, got_w;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (prev_sclk && sclk_o && prev_sdat && !sdat_o) begin
                in_frame  = 1'b1;
                fell      = 1'b0;
                nbits     = 0;
                bits      = '0;
                start_cyc = cyc;
                last_gap  = idle_run;
            end else if (in_frame) begin
                if (!prev_sclk && sclk_o) begin
                    bits = {bits[62:0], sdat_o};
                    nbits++;
                end
                if (prev_sclk && !sclk_o && !fell) begin
                    fell = 1'b1;
                    check("first_sclk_fall", 64'(cyc - start_cyc), 64'(HALF));
                end
                if (prev_sclk && sclk_o && !prev_sdat && sdat_o) begin
                    in_frame = 1'b0;
                    frames++;
                    check("frame_bits", 64'(nbits), 64'(DATA_W + P + 1));
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 64'(1), 64'(0));
                    end else begin
                        exp_w = exp_q.pop_front();
                        got_w = DATA_W'(bits >> (P + 1));
                        check("frame_data", 64'(got_w), 64'(exp_w));
                        check("stop_low_bit", 64'(bits[0]), 64'(0));
`ifdef TWO_WIRE_TX_PARITY_EN
                        check("parity_bit", 64'(bits[1]), 64'(^exp_w));
`endif
                    end
                end
            end
            if (busy && !prev_busy) busy_start = cyc;
            if (done) begin
                check("busy_len", 64'(cyc - busy_start), 64'(FRAME));
                check("busy_at_done", 64'(busy), 64'(0));
            end
        end
        idle_run  = (sclk_o && sdat_o) ? idle_run + 1 : 0;
        prev_sclk = sclk_o;
        prev_sdat = sdat_o;
        prev_busy = busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] word);
        step();
        din   = word;
        start = 1'b1;
        exp_q.push_back(word);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'(0), 64'(1));
    endtask

    int frames_before;

    initial begin
        // Reset held three cycles with start pulses that must be dropped.
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            din   = 16'hBEEF;
            step();
            check("reset_outputs", 64'({sclk_o, sdat_o, busy, done}), 64'(4'b1100));
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (5) step();
        check("start_in_reset_dropped", 64'({sclk_o, sdat_o, busy}), 64'(3'b110));

        // Single frame with accept-edge timing.
        send(16'hA5C3);
        check("accept_busy", 64'(busy), 64'(1));
        check("accept_sdat", 64'(sdat_o), 64'(0));
        check("accept_sclk", 64'(sclk_o), 64'(1));
        wait_done(FRAME + 10);
        repeat (3) step();

        // Parity extremes (plain payloads when parity is not compiled in).
        send(16'h0001);
        wait_done(FRAME + 10);
        send(16'h0000);
        wait_done(FRAME + 10);
        repeat (3) step();

        // Start while busy with a different word must be ignored.
        frames_before = frames;
        send(16'h3C5A);
        repeat (98) step();
        din   = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(FRAME + 10);
        repeat (2 * FRAME) step();
        check("collision_no_second_frame", 64'(frames - frames_before), 64'(1));
        check("collision_idle", 64'(busy), 64'(0));

        // Back-to-back with start held high.
        frames_before = frames;
        step();
        din   = 16'h1234;
        start = 1'b1;
        exp_q.push_back(16'h1234);
        wait_done(FRAME + 10);
        din = 16'h8001;
        exp_q.push_back(16'h8001);
        step();
        check("b2b_reaccept", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done(FRAME + 10);
        repeat (3) step();
        check("b2b_idle_gap", 64'(last_gap), 64'(1));
        check("b2b_frames", 64'(frames - frames_before), 64'(2));

        // Reset in the middle of a frame, then a clean frame.
        frames_before = frames;
        send(16'h0F0F);
        repeat (298) step();
        rst = 1'b1;
        step();
        check("midreset_outputs", 64'({sclk_o, sdat_o, busy, done}), 64'(4'b1100));
        step();
        rst = 1'b0;
        exp_q.delete();
        repeat (5) step();
        check("midreset_no_frame", 64'(frames - frames_before), 64'(0));
        send(16'h5AA5);
        wait_done(FRAME + 10);
        repeat (3) step();
        check("post_reset_frame", 64'(frames - frames_before), 64'(1));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
